// File: rtl/xbar_bank_req_buf.sv
// Per-channel, per-bank request buffer: 8-slot entry array written at w_ptr and drained at r_ptr,
// presenting the beats of the r_ptr entry to one bank in ascending order over a valid/ready handshake.
module xbar_bank_req_buf #(
   parameter  int PTR_W    = 3,
   parameter  int BEAT_NUM = 4,
   parameter  int ADDR_W   = 16,
   parameter  int DATA_W   = 32,
   localparam int IDX_W    = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [PTR_W-1:0]           w_ptr,
   input  logic [BEAT_NUM-1:0]        wr_beat_mask,
   input  logic [BEAT_NUM*ADDR_W-1:0] wr_addr,
   input  logic [BEAT_NUM*DATA_W-1:0] wr_data,
   input  logic                       wr_we,
   input  logic [PTR_W-1:0]           r_ptr,
   output logic                       bank_req_valid,
   input  logic                       bank_req_ready,
   output logic [ADDR_W-1:0]          bank_req_addr,
   output logic [DATA_W-1:0]          bank_req_data,
   output logic                       bank_req_we,
   output logic [IDX_W-1:0]           bank_req_beat_idx,
   output logic                       last_entry_already_pop,
   output logic                       wr_ovf_err
);

   localparam int NUM_ENTRY = 1 << PTR_W;

   logic [NUM_ENTRY-1:0] valid_r;
   logic [BEAT_NUM-1:0]  rem_r  [NUM_ENTRY];
   logic [ADDR_W-1:0]    addr_r [NUM_ENTRY][BEAT_NUM];
   logic [DATA_W-1:0]    data_r [NUM_ENTRY][BEAT_NUM];
   logic [NUM_ENTRY-1:0] we_r;
   logic [PTR_W-1:0]     r_ptr_q_r;
   logic                 wr_ovf_err_r;

   logic                 cur_valid_s;
   logic [BEAT_NUM-1:0]  cur_rem_s;
   logic [IDX_W-1:0]     beat_idx_s;
   logic                 pop_s;
   logic                 retire_s;
   logic                 ovf_s;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [BEAT_NUM-1:0] mask);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = BEAT_NUM - 1; i >= 0; i--) begin
         idx = mask[i] ? IDX_W'(i) : idx;
      end
      return idx;
   endfunction

   // Beat presentation, handshake, retire detection and overflow qualification
   always_comb begin
      cur_valid_s            = valid_r[r_ptr];
      cur_rem_s              = rem_r[r_ptr];
      beat_idx_s             = lowest_set(cur_rem_s);
      bank_req_valid         = cur_valid_s & (|cur_rem_s);
      bank_req_addr          = addr_r[r_ptr][beat_idx_s];
      bank_req_data          = data_r[r_ptr][beat_idx_s];
      bank_req_we            = we_r[r_ptr];
      bank_req_beat_idx      = beat_idx_s;
      last_entry_already_pop = cur_valid_s & ~(|cur_rem_s);
      pop_s                  = bank_req_valid & bank_req_ready;
      retire_s               = (r_ptr != r_ptr_q_r);
      // A slot being retired on this same edge is free, so writing it is not an overflow
      ovf_s                  = wr_en & valid_r[w_ptr] & ~(retire_s & (w_ptr == r_ptr_q_r));
   end

   assign wr_ovf_err = wr_ovf_err_r;

   // Slot control state; later assignments win, so a write overrides a same-edge retire or pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r      <= {NUM_ENTRY{1'b0}};
         r_ptr_q_r    <= {PTR_W{1'b0}};
         wr_ovf_err_r <= 1'b0;
         for (int e = 0; e < NUM_ENTRY; e++) begin
            rem_r[e] <= {BEAT_NUM{1'b0}};
         end
      end else begin
         r_ptr_q_r <= r_ptr;
         if (retire_s) begin
            valid_r[r_ptr_q_r] <= 1'b0;
         end
         if (pop_s) begin
            rem_r[r_ptr][beat_idx_s] <= 1'b0;
         end
         if (wr_en) begin
            valid_r[w_ptr] <= 1'b1;
            rem_r[w_ptr]   <= wr_beat_mask;
         end
         if (ovf_s) begin
            wr_ovf_err_r <= 1'b1;
         end
      end
   end

   // Payload storage, only meaningful while the slot is valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         we_r[w_ptr] <= wr_we;
         for (int b = 0; b < BEAT_NUM; b++) begin
            addr_r[w_ptr][b] <= wr_addr[b*ADDR_W +: ADDR_W];
            data_r[w_ptr][b] <= wr_data[b*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_xbar_bank_req_buf.sv
// Directed bench for xbar_bank_req_buf: writes push expected beats into a scoreboard queue,
// a negedge monitor pops and compares every accepted beat.
module tb_xbar_bank_req_buf;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [2:0]    w_ptr;
   logic [3:0]    wr_beat_mask;
   logic [63:0]   wr_addr;
   logic [127:0]  wr_data;
   logic          wr_we;
   logic [2:0]    r_ptr;
   logic          bank_req_valid;
   logic          bank_req_ready;
   logic [15:0]   bank_req_addr;
   logic [31:0]   bank_req_data;
   logic          bank_req_we;
   logic [1:0]    bank_req_beat_idx;
   logic          last_entry_already_pop;
   logic          wr_ovf_err;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      logic        we;
      logic [1:0]  idx;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    popped = 0;

   xbar_bank_req_buf dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_ptr(w_ptr), .wr_beat_mask(wr_beat_mask),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we), .r_ptr(r_ptr),
      .bank_req_valid(bank_req_valid), .bank_req_ready(bank_req_ready),
      .bank_req_addr(bank_req_addr), .bank_req_data(bank_req_data), .bank_req_we(bank_req_we),
      .bank_req_beat_idx(bank_req_beat_idx), .last_entry_already_pop(last_entry_already_pop),
      .wr_ovf_err(wr_ovf_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] f_addr(input logic [7:0] base, input int b);
      return {base, 4'h0, 4'(b)};
   endfunction

   function automatic logic [31:0] f_data(input logic [7:0] base, input int b);
      return {8'hC3, base, 8'(b), base ^ 8'h5A};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One-cycle write; when push is set the beats are queued in the order the DUT must issue them
   task automatic do_wr(input logic [2:0] ptr, input logic [3:0] mask, input logic we,
                        input logic [7:0] base, input bit push);
      beat_t bt;
      wr_en = 1'b1;
      w_ptr = ptr;
      wr_beat_mask = mask;
      wr_we = we;
      for (int b = 0; b < 4; b++) begin
         wr_addr[b*16 +: 16] = f_addr(base, b);
         wr_data[b*32 +: 32] = f_data(base, b);
         if (push && mask[b]) begin
            bt.addr = f_addr(base, b);
            bt.data = f_data(base, b);
            bt.we   = we;
            bt.idx  = 2'(b);
            exp_q.push_back(bt);
         end
      end
      tick();
      wr_en = 1'b0;
   endtask

   // Scoreboard monitor: every accepted beat must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && bank_req_valid && bank_req_ready) begin
         checks++;
         popped++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected actual addr=%0h idx=%0d required none", bank_req_addr, bank_req_beat_idx);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (bank_req_addr !== e.addr || bank_req_data !== e.data ||
                bank_req_we !== e.we || bank_req_beat_idx !== e.idx) begin
               failures++;
               $display("FAIL beat actual addr=%0h data=%0h we=%0b idx=%0d required addr=%0h data=%0h we=%0b idx=%0d",
                        bank_req_addr, bank_req_data, bank_req_we, bank_req_beat_idx,
                        e.addr, e.data, e.we, e.idx);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rst_n = 1'b0; wr_en = 1'b0; w_ptr = 3'd0; wr_beat_mask = 4'd0; wr_addr = '0; wr_data = '0;
      wr_we = 1'b0; r_ptr = 3'd0; bank_req_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_valid", 64'(bank_req_valid), 64'd0);
      chk("rst_leap", 64'(last_entry_already_pop), 64'd0);
      chk("rst_err", 64'(wr_ovf_err), 64'd0);

      // 1: mask 1011 drains beats 0,1,3 back to back
      bank_req_ready = 1'b1;
      p0 = popped;
      do_wr(3'd0, 4'b1011, 1'b1, 8'h10, 1'b1);
      chk("t1_valid", 64'(bank_req_valid), 64'd1);
      tick(); tick();
      chk("t1_leap_early", 64'(last_entry_already_pop), 64'd0);
      chk("t1_idx3", 64'(bank_req_beat_idx), 64'd3);
      tick();
      chk("t1_leap", 64'(last_entry_already_pop), 64'd1);
      chk("t1_valid_done", 64'(bank_req_valid), 64'd0);
      chk("t1_beats", 64'(popped - p0), 64'd3);

      // 2: empty mask at w_ptr=r_ptr=2, then retire on advance
      r_ptr = 3'd2;
      tick();
      chk("t2_leap_pre", 64'(last_entry_already_pop), 64'd0);
      do_wr(3'd2, 4'b0000, 1'b0, 8'h20, 1'b1);
      chk("t2_valid", 64'(bank_req_valid), 64'd0);
      chk("t2_leap", 64'(last_entry_already_pop), 64'd1);
      r_ptr = 3'd3;
      tick();
      r_ptr = 3'd2;
      #1;
      chk("t2_retired", 64'(last_entry_already_pop), 64'd0);
      r_ptr = 3'd3;

      // 3: five-cycle stall keeps the presented beat stable
      bank_req_ready = 1'b0;
      do_wr(3'd3, 4'b0110, 1'b1, 8'h30, 1'b1);
      for (int c = 0; c < 5; c++) begin
         chk("t3_valid", 64'(bank_req_valid), 64'd1);
         chk("t3_idx", 64'(bank_req_beat_idx), 64'd1);
         chk("t3_addr", 64'(bank_req_addr), 64'(f_addr(8'h30, 1)));
         chk("t3_data", 64'(bank_req_data), 64'(f_data(8'h30, 1)));
         tick();
      end
      bank_req_ready = 1'b1;
      tick(); tick();
      chk("t3_leap", 64'(last_entry_already_pop), 64'd1);

      // 4: fill all slots with w_ptr wrapping while a reader advances r_ptr on leap
      fork
         begin
            logic [3:0] masks [8];
            masks = '{4'b0001, 4'b1111, 4'b1000, 4'b0101, 4'b0000, 4'b1010, 4'b0011, 4'b1100};
            for (int k = 0; k < 8; k++) begin
               do_wr(3'(4 + k), masks[k], 1'(k), 8'(8'h40 + k), 1'b1);
            end
         end
         begin
            int adv = 0;
            int cyc = 0;
            while (adv < 8 && cyc < 300) begin
               if (last_entry_already_pop) begin
                  r_ptr = r_ptr + 3'd1;
                  adv++;
               end
               tick();
               cyc++;
            end
            cyc = 0;
            while (!last_entry_already_pop && cyc < 50) begin
               tick();
               cyc++;
            end
            chk("t4_advances", 64'(adv), 64'd8);
            chk("t4_final_leap", 64'(last_entry_already_pop), 64'd1);
         end
      join
      chk("t4_err", 64'(wr_ovf_err), 64'd0);
      chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

      // 5: write to slot 5 on the edge that retires it
      r_ptr = 3'd5;
      tick();
      do_wr(3'd5, 4'b0011, 1'b0, 8'h50, 1'b1);
      tick(); tick();
      chk("t5_leap", 64'(last_entry_already_pop), 64'd1);
      bank_req_ready = 1'b0;
      r_ptr = 3'd6;
      do_wr(3'd5, 4'b1001, 1'b1, 8'h58, 1'b1);
      chk("t5_err", 64'(wr_ovf_err), 64'd0);
      r_ptr = 3'd5;
      #1;
      chk("t5_valid", 64'(bank_req_valid), 64'd1);
      chk("t5_idx", 64'(bank_req_beat_idx), 64'd0);
      chk("t5_addr", 64'(bank_req_addr), 64'(f_addr(8'h58, 0)));
      bank_req_ready = 1'b1;
      tick(); tick();
      chk("t5_leap_new", 64'(last_entry_already_pop), 64'd1);

      // 6: overflow is sticky; async reset mid-drain clears everything
      bank_req_ready = 1'b0;
      do_wr(3'd7, 4'b1111, 1'b0, 8'h60, 1'b0);
      chk("t6_err_pre", 64'(wr_ovf_err), 64'd0);
      do_wr(3'd7, 4'b0110, 1'b1, 8'h70, 1'b1);
      chk("t6_err", 64'(wr_ovf_err), 64'd1);
      tick(); tick();
      chk("t6_err_sticky", 64'(wr_ovf_err), 64'd1);
      r_ptr = 3'd7;
      bank_req_ready = 1'b1;
      tick();
      chk("t6_mid_idx", 64'(bank_req_beat_idx), 64'd2);
      #2;
      rst_n = 1'b0;
      r_ptr = 3'd0;
      #1;
      chk("t6_rst_valid", 64'(bank_req_valid), 64'd0);
      chk("t6_rst_leap", 64'(last_entry_already_pop), 64'd0);
      chk("t6_rst_err", 64'(wr_ovf_err), 64'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_post_valid", 64'(bank_req_valid), 64'd0);
      chk("end_q_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
